// File: rtl/stream_topk_drain.sv
// Streaming top-K tracker: keeps the K largest samples sorted and drains them largest-first.
// Define STREAM_TOPK_SIGNED_EN to rank samples as two's-complement signed values.
module stream_topk_drain #(
   parameter int DATA_WIDTH = 32,
   parameter int K          = 4
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic [DATA_WIDTH-1:0]    din,
   input  logic                     din_valid,
   input  logic                     drain,
   output logic [DATA_WIDTH-1:0]    dout,
   output logic                     dout_valid,
   input  logic                     dout_ready,
   output logic                     dout_last,
   output logic                     busy,
   output logic [$clog2(K+1)-1:0]   count
);
   localparam int CW = $clog2(K+1);

   typedef enum logic {ACCUM, DRAIN} state_t;

   state_t                state;
   logic [DATA_WIDTH-1:0] entry     [K];
   logic [DATA_WIDTH-1:0] ins_entry [K];
   logic [CW-1:0]         pos;
   logic [CW-1:0]         ins_count;
   logic                  accept;

   function automatic logic at_least(input logic [DATA_WIDTH-1:0] a,
                                     input logic [DATA_WIDTH-1:0] b);
`ifdef STREAM_TOPK_SIGNED_EN
      return $signed(a) >= $signed(b);
`else
      return a >= b;
`endif
   endfunction

   // Insertion slot = number of occupied entries ranking at or above din, so ties land after equals.
   always_comb begin
      pos = '0;
      for (int i = 0; i < K; i++) begin
         if (CW'(i) < count && at_least(entry[i], din))
            pos = pos + CW'(1);
      end
      accept    = din_valid && (pos != CW'(K));
      ins_entry = entry;
      ins_count = count;
      if (accept) begin
         ins_entry[0] = (pos == '0) ? din : entry[0];
         for (int i = 1; i < K; i++) begin
            if (CW'(i) == pos)
               ins_entry[i] = din;
            else if (CW'(i) > pos)
               ins_entry[i] = entry[i-1];
         end
         if (count != CW'(K))
            ins_count = count + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state      <= ACCUM;
         count      <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
         dout_last  <= 1'b0;
         busy       <= 1'b0;
         for (int i = 0; i < K; i++)
            entry[i] <= '0;
      end else begin
         case (state)
            ACCUM: begin
               entry <= ins_entry;
               count <= ins_count;
               // Drain sees the post-insert contents, so a same-cycle sample is included.
               if (drain && ins_count != '0) begin
                  state      <= DRAIN;
                  busy       <= 1'b1;
                  dout_valid <= 1'b1;
                  dout       <= ins_entry[0];
                  dout_last  <= (ins_count == CW'(1));
               end
            end
            DRAIN: begin
               if (dout_ready) begin
                  if (dout_last) begin
                     state      <= ACCUM;
                     count      <= '0;
                     dout       <= '0;
                     dout_valid <= 1'b0;
                     dout_last  <= 1'b0;
                     busy       <= 1'b0;
                     for (int i = 0; i < K; i++)
                        entry[i] <= '0;
                  end else begin
                     for (int i = 0; i < K-1; i++)
                        entry[i] <= entry[i+1];
                     entry[K-1] <= '0;
                     count      <= count - CW'(1);
                     dout       <= entry[1];
                     dout_last  <= (count == CW'(2));
                  end
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end
endmodule
